// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state codes, frame-format limits and baud divider helper
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 8;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - write/status bus between the CPU register side and the buffered UART transmitter
interface uart_tx_buffered_if #(
    parameter int FIFO_DEPTH = 16
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          write_en;
    logic [7:0]    data;
    logic          uart_busy;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    modport master (
        output write_en, data,
        input  uart_busy, fifo_full, fifo_empty, fifo_count
    );

    modport slave (
        input  write_en, data,
        output uart_busy, fifo_full, fifo_empty, fifo_count
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with occupancy count; pushes while full and pops while empty are ignored
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered UART transmitter, back-to-back frames
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_buffered_if.slave  bus,
    output logic               tx
);
    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
    localparam int BCW      = $clog2(BAUD_DIV);
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("BAUD_DIV must be at least 2");
    end
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("DATA_BITS out of range");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("STOP_BITS out of range");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("PARITY_ODD must be 0 or 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    logic [2:0]           state;
    logic [BCW-1:0]       baud_cnt;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        count_next;
    logic                 pop;
    logic                 push_ok;
    logic                 bit_end;
    logic                 frame_end;
    logic                 going_idle;
    logic                 busy;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.write_en),
        .wdata (bus.data[DATA_BITS-1:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end    = (baud_cnt == BCW'(BAUD_DIV - 1));
    assign frame_end  = (state == ST_STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1));
    assign pop        = !fifo_empty && ((state == ST_IDLE) || frame_end);
    assign push_ok    = bus.write_en && !fifo_full;
    assign going_idle = !pop && ((state == ST_IDLE) || frame_end);
    assign count_next = fifo_count + CW'(push_ok) - CW'(pop);

    // A pop always wins: it is what chains the next start bit straight after the last stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '1;
            busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b1;
`endif
        end else begin
            busy <= !going_idle || (count_next != '0);
            if (pop) begin
                shreg    <= fifo_rdata;
                state    <= ST_START;
                baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= (^fifo_rdata) ^ 1'(PARITY_ODD);
`endif
            end else begin
                case (state)
                    ST_IDLE: baud_cnt <= '0;
                    ST_START: begin
                        if (bit_end) begin
                            state    <= ST_DATA;
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                        end else baud_cnt <= baud_cnt + 1'b1;
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            shreg    <= {1'b1, shreg[DATA_BITS-1:1]};
                            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                                stop_idx <= 1'b0;
                            end else bit_idx <= bit_idx + 3'd1;
                        end else baud_cnt <= baud_cnt + 1'b1;
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        if (bit_end) begin
                            state    <= ST_STOP;
                            baud_cnt <= '0;
                            stop_idx <= 1'b0;
                        end else baud_cnt <= baud_cnt + 1'b1;
                    end
`endif
                    ST_STOP: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            if (frame_end) state <= ST_IDLE;
                            else stop_idx <= stop_idx + 1'b1;
                        end else baud_cnt <= baud_cnt + 1'b1;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        baud_cnt <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shreg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = parity_bit;
`endif
            default:   tx = 1'b1;
        endcase
    end

    assign bus.uart_busy  = busy;
    assign bus.fifo_full  = fifo_full;
    assign bus.fifo_empty = fifo_empty;
    assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - randomized scoreboard bench for uart_tx_buffered with a frame-level reference model
module tb_uart_tx_buffered;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int BD       = CLK_FREQ / BAUD;
    localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
    localparam int DB = 7;
    localparam int SB = 2;
    localparam int PO = 1;
    localparam int PB = 1;
`else
    localparam int DB = 8;
    localparam int SB = 1;
    localparam int PO = 0;
    localparam int PB = 0;
`endif
    localparam int NB   = 1 + DB + PB + SB;
    localparam int L    = NB * BD;
    localparam int MASK = (1 << DB) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;

    uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .DATA_BITS  (DB),
        .STOP_BITS  (SB),
        .PARITY_ODD (PO),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int par_of(input int b);
        return ($countones(b & MASK) & 1) ^ PO;
    endfunction

    // Reference model: FIFO as a queue, the line as a frame timer counting down from L.
    int mq[$];
    int sbq[$];
    int frame_left = 0;
    int cur_byte   = 0;
    int rst_seen   = 0;

    always @(posedge clk) begin
        int cnt0;
        int do_pop;
        int exp_tx;
        int pos;
        int k;
        if (rst) begin
            mq.delete();
            sbq.delete();
            frame_left = 0;
            rst_seen   = 1;
        end else begin
            cnt0   = mq.size();
            do_pop = 0;
            if (frame_left == 0) do_pop = (cnt0 > 0);
            else begin
                frame_left--;
                if (frame_left == 0) do_pop = (cnt0 > 0);
            end
            if (do_pop != 0) begin
                cur_byte   = mq.pop_front();
                frame_left = L;
            end
            if (bus.write_en && cnt0 < DEPTH) begin
                mq.push_back(int'(bus.data) & MASK);
                sbq.push_back(int'(bus.data) & MASK);
            end
        end
        #2;
        exp_tx = 1;
        if (frame_left > 0) begin
            pos = L - frame_left;
            k   = pos / BD;
            if (k == 0) exp_tx = 0;
            else if (k <= DB) exp_tx = (cur_byte >> (k - 1)) & 1;
            else if (PB != 0 && k == DB + 1) exp_tx = par_of(cur_byte);
        end
        chk("tx", int'(tx), exp_tx);
        chk("fifo_count", int'(bus.fifo_count), mq.size());
        chk("fifo_full", int'(bus.fifo_full), int'(mq.size() == DEPTH));
        chk("fifo_empty", int'(bus.fifo_empty), int'(mq.size() == 0));
        chk("uart_busy", int'(bus.uart_busy), int'(frame_left > 0 || mq.size() > 0));
    end

    // Monitor: decodes frames from the line by mid-bit sampling and checks them against the scoreboard.
    int in_frame = 0;
    int c        = 0;
    int prev_tx  = 1;
    int rx       = 0;
    int start_v  = 0;
    int par_v    = 1;
    int stop_ok  = 1;

    always @(negedge clk) begin
        int k;
        int exp_b;
        if (rst || rst_seen != 0) begin
            in_frame = 0;
            rst_seen = 0;
            prev_tx  = 1;
        end else begin
            if (in_frame == 0 && prev_tx == 1 && tx == 1'b0) begin
                in_frame = 1;
                c        = 0;
                rx       = 0;
                par_v    = 1;
                stop_ok  = 1;
            end
            if (in_frame != 0) begin
                if (c % BD == BD / 2) begin
                    k = c / BD;
                    if (k == 0) start_v = int'(tx);
                    else if (k <= DB) rx = rx | (int'(tx) << (k - 1));
                    else if (PB != 0 && k == DB + 1) par_v = int'(tx);
                    else stop_ok = stop_ok & int'(tx);
                    if (k == NB - 1) begin
                        in_frame = 0;
                        if (sbq.size() == 0) chk("frame_unexpected", rx, -1);
                        else begin
                            exp_b = sbq.pop_front();
                            chk("frame_data", rx, exp_b);
                            chk("frame_start", start_v, 0);
                            chk("frame_stop", stop_ok, 1);
                            chk("frame_parity", par_v, (PB != 0) ? par_of(exp_b) : 1);
                        end
                    end
                end
                c++;
            end
            prev_tx = int'(tx);
        end
    end

    task automatic drive(input int we, input int b);
        @(negedge clk);
        bus.write_en = we[0];
        bus.data     = b[7:0];
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((frame_left != 0 || mq.size() != 0) && n < (DEPTH + 2) * L + 50) begin
            @(negedge clk);
            n++;
        end
        if (frame_left != 0 || mq.size() != 0) chk("idle_timeout", n, -1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        bus.write_en = 1'b0;
        bus.data     = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(bus.uart_busy), 0);
        chk("reset_empty", int'(bus.fifo_empty), 1);
        chk("reset_full", int'(bus.fifo_full), 0);
        chk("reset_count", int'(bus.fifo_count), 0);
        @(negedge clk);
        rst = 1'b0;

        drive(1, 8'h55); drive(0, 0);
        wait_idle();

        drive(1, 8'hA5); drive(1, 8'h3C); drive(1, 8'hFF); drive(0, 0);
        wait_idle();

        for (int i = 0; i < 6; i++) drive(1, int'($urandom_range(0, 255)));
        drive(0, 0);
        chk("overflow_full", int'(bus.fifo_full), 1);
        chk("overflow_count", int'(bus.fifo_count), DEPTH);
        wait_idle();

        drive(1, 8'h03); drive(0, 0);
        wait_idle();

        drive(1, int'($urandom_range(0, 255))); drive(1, 8'h96); drive(0, 0);
        repeat (1 + 4 * BD + BD / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midframe_rst_tx", int'(tx), 1);
        chk("midframe_rst_busy", int'(bus.uart_busy), 0);
        chk("midframe_rst_empty", int'(bus.fifo_empty), 1);
        chk("midframe_rst_count", int'(bus.fifo_count), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 8'hC7); drive(0, 0);
        wait_idle();

        drive(1, 8'h12); drive(1, 8'h34); drive(0, 0);
        n = 0;
        while (!(frame_left == 1 && mq.size() == 1) && n < 2 * L) begin
            @(negedge clk);
            n++;
        end
        if (!(frame_left == 1 && mq.size() == 1)) chk("last_pop_timeout", n, -1);
        bus.write_en = 1'b1;
        bus.data     = 8'h5A;
        @(negedge clk);
        bus.write_en = 1'b0;
        chk("push_on_last_pop_count", int'(bus.fifo_count), 1);
        wait_idle();

        for (int i = 0; i < 3000; i++)
            drive(int'($urandom_range(0, 24) == 0), int'($urandom_range(0, 255)));
        drive(0, 0);
        wait_idle();

        chk("scoreboard_drained", sbq.size(), 0);
        chk("monitor_idle", in_frame, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised UART transmitter with an internal write FIFO, configurable frame format (data bits, stop bits, optional parity) and back-to-back frame transmission. Sits between the CPU's memory-mapped UART register and the board TX pin, replacing the unbuffered single-byte transmitter. Software can queue up to FIFO_DEPTH bytes without polling per byte.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate; BAUD_DIV = CLK_FREQ / BAUD (truncating integer divide), must be ≥ 2.
- DATA_BITS, 8: data bits per frame, legal range 5..8.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; used only when parity is compiled in.
- FIFO_DEPTH, 16: FIFO entries, power of two, ≥ 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- write_en  in  1  push request; accepted on an edge where fifo_full is 0.
- data  in  8  byte to queue; only bits [DATA_BITS-1:0] are transmitted.
- tx  out  1  serial line, idle high.
- uart_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  out  1  FIFO holds no entries.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Reset values: tx=1, uart_busy=0, fifo_full=0, fifo_empty=1, fifo_count=0, FSM in IDLE, baud counter 0. Reset mid-frame aborts immediately, FIFO contents discarded.
- Push: write_en && !fifo_full → data written, count+1. write_en while full → silently dropped, no state change.
- Simultaneous push and FSM pop with FIFO non-full → both happen, count unchanged. Pop happens only when non-empty; push into an empty FIFO is not bypassed.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: tx=1; if !fifo_empty, pop into shift register, enter START.
  - START: tx=0 for BAUD_DIV cycles.
  - DATA: DATA_BITS bits, LSB first, each BAUD_DIV cycles.
  - PARITY: one bit = XOR of data bits, inverted if PARITY_ODD.
  - STOP: tx=1 for STOP_BITS×BAUD_DIV cycles; at end, if FIFO non-empty pop and go directly to START (no idle gap), else IDLE.
- Baud counter runs only outside IDLE; reloaded to 0 on every state/bit transition, so every bit is exactly BAUD_DIV cycles.
- uart_busy = (state != IDLE) || !fifo_empty, registered.

## Timing
- Push at edge N into empty FIFO with FSM idle: fifo_empty falls after edge N; tx falls after edge N+1 (pop edge).
- Frame length = (1 + DATA_BITS + P + STOP_BITS) × BAUD_DIV cycles, P = 1 with parity, else 0.
- Back-to-back frames: next start bit begins on the edge that ends the last stop bit.
- fifo_full/fifo_empty/fifo_count update on the same edge as the push/pop.
- uart_busy falls on the edge the FSM returns to IDLE with FIFO empty.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state present, parity bit inserted per PARITY_ODD.
- Undefined: no PARITY state, frame has no parity bit, PARITY_ODD ignored.

## Structure
- Shared package uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP), BAUD_DIV computation function, legal-range constants for DATA_BITS/STOP_BITS.
- One sub-module: uart_sync_fifo (parametrised width/depth, push/pop, full/empty/count, async active-high reset). Transmit FSM and baud counter stay in the top.

## Test plan
- CLK_FREQ=1_000_000, BAUD=100_000 (BAUD_DIV=10), 8N1, push 0x55 → tx low 10 cycles from edge N+1, then 1,0,1,0,1,0,1,0 at 10 cycles each, high 10 cycles; uart_busy high for 100 cycles then low.
- Push 0xA5, 0x3C, 0xFF on consecutive cycles → three 100-cycle frames with no idle between; fifo_count sequence 1,1,2 then decrements per pop.
- FIFO_DEPTH=4, push 6 bytes while first frame is on the line → 5 accepted (1 popped + 4 stored), 6th dropped, fifo_full=1; exactly 5 frames emitted.
- UART_TX_PARITY_EN, DATA_BITS=7, STOP_BITS=2, PARITY_ODD=1, push 0x03 → bits start,1,1,0,0,0,0,0, parity 1, two stop bits; frame 110 cycles.
- Assert rst for 1 cycle mid data bit 3 → tx=1, uart_busy=0, fifo_empty=1, fifo_count=0 immediately; next push transmits a clean frame.
- Push on the exact cycle FSM pops last entry with count=1 → count stays 1, next frame follows back-to-back.
